max_pool_store: RTL and testbench

- Write-back end of the max-pool stage. `max_pool_fill` generates the read addresses for the pooling windows; this block is its counterpart on the write side.
- Accepts the stream of pooled results from the comparator tree over a valid/ready handshake.
- Writes each result into the output feature-map buffer, in raster order, starting from a base address.
- Asserts done when the full OUT_W x OUT_H output tile has been written.

---
 rtl/cnn_defs.sv | 15 +
 rtl/raster_addr_gen.sv | 55 +++++
 rtl/max_pool_store.sv | 134 +++++++++++++
 tb/tb_max_pool_store.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_defs.sv
// cnn_defs: shared defaults and state encoding for the CNN pooling datapath.
`default_nettype none

package cnn_defs;

    localparam int ADD_SIZE_DEF  = 14;
    localparam int DATA_SIZE_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/raster_addr_gen.sv
// raster_addr_gen: row/col counters with an accumulated row base; addr = row_base + col.
`default_nettype none

module raster_addr_gen #(
    parameter int ADD_SIZE   = 14,
    parameter int OUT_W      = 14,
    parameter int OUT_H      = 14,
    parameter int ROW_STRIDE = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                step,
    input  logic [ADD_SIZE-1:0] base,
    output logic [ADD_SIZE-1:0] addr,
    output logic                last
);

    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam logic [COL_W-1:0]    c_COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]    c_ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [ADD_SIZE-1:0] c_STRIDE   = ADD_SIZE'(ROW_STRIDE);

    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [ADD_SIZE-1:0] r_row_base;

    // Strides are accumulated rather than multiplied; wrap is modulo 2^ADD_SIZE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (start) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= base;
        end else if (step) begin
            if (r_col == c_COL_LAST) begin
                r_col      <= '0;
                r_row      <= r_row + 1'b1;
                r_row_base <= r_row_base + c_STRIDE;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign addr = r_row_base + ADD_SIZE'(r_col);
    assign last = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

endmodule

`default_nettype wire

// File: rtl/max_pool_store.sv
// max_pool_store: writes a stream of pooled results into the output buffer in raster order.
// Optional ReLU on write-back when MAX_POOL_STORE_RELU_EN is defined.
`default_nettype none

module max_pool_store
    import cnn_defs::*;
#(
    parameter int ADD_SIZE   = ADD_SIZE_DEF,
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int OUT_W      = 14,
    parameter int OUT_H      = 14,
    parameter int ROW_STRIDE = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ADD_SIZE-1:0]  add_in,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [ADD_SIZE-1:0]  add_out,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_in_ready;
    logic                 w_in_ready_nxt;
    logic                 w_start;
    logic                 w_xfer;
    logic                 w_last;
    logic [ADD_SIZE-1:0]  w_addr;
    logic [DATA_SIZE-1:0] w_data;
    logic                 r_wr_en;
    logic [ADD_SIZE-1:0]  r_add_out;
    logic [DATA_SIZE-1:0] r_wr_data;
    logic                 r_done;

    raster_addr_gen #(
        .ADD_SIZE   (ADD_SIZE),
        .OUT_W      (OUT_W),
        .OUT_H      (OUT_H),
        .ROW_STRIDE (ROW_STRIDE)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .step  (w_xfer),
        .base  (add_in),
        .addr  (w_addr),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    // in_ready is only ever high in RUN, so it alone qualifies a transfer.
    always_comb begin
        w_next         = r_state;
        w_in_ready_nxt = 1'b0;
        w_start        = 1'b0;
        w_xfer         = in_valid && r_in_ready;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next         = S_RUN;
                    w_start        = 1'b1;
                    w_in_ready_nxt = 1'b1;
                end
            end
            S_RUN: begin
                w_in_ready_nxt = 1'b1;
                if (w_xfer && w_last) begin
                    w_next         = S_DONE;
                    w_in_ready_nxt = 1'b0;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef MAX_POOL_STORE_RELU_EN
    assign w_data = in_data[DATA_SIZE-1] ? '0 : in_data;
`else
    assign w_data = in_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_add_out <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= w_xfer;
            r_done  <= (w_next == S_DONE);
            if (w_xfer) begin
                r_add_out <= w_addr;
                r_wr_data <= w_data;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign wr_en    = r_wr_en;
    assign add_out  = r_add_out;
    assign wr_data  = r_wr_data;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_max_pool_store.sv
// tb_max_pool_store: randomized scoreboard bench for max_pool_store on a 4x4 tile, row stride 16.
`default_nettype none

module tb_max_pool_store;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int OW = 4;
    localparam int OH = 4;
    localparam int RS = 16;
    localparam int N  = OW * OH;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          enable   = 1'b0;
    logic [AW-1:0] add_in   = '0;
    logic [DW-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] add_out;
    logic [DW-1:0] wr_data;
    logic          done;

    max_pool_store #(
        .ADD_SIZE   (AW),
        .DATA_SIZE  (DW),
        .OUT_W      (OW),
        .OUT_H      (OH),
        .ROW_STRIDE (RS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .add_in   (add_in),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .add_out  (add_out),
        .wr_data  (wr_data),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            nwr    = 0;
    logic [AW-1:0] m_base;
    int            m_k;

    function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] d);
`ifdef MAX_POOL_STORE_RELU_EN
        return ($signed(d) < 0) ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write must match the oldest outstanding expected element.
    always @(negedge clk) begin
        exp_t e;
        if (reset && wr_en) begin
            nwr++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h required no write", add_out);
            end else begin
                e = q.pop_front();
                check("wr_addr", 32'(add_out), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
                check("done_with_write", 32'(done), 32'(e.last));
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [DW-1:0] d);
        int   t;
        exp_t e;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 32'(in_ready), 32'd1);
        if (in_ready) begin
            e.a    = AW'(int'(m_base) + (m_k / OW) * RS + (m_k % OW));
            e.d    = ref_data(d);
            e.last = (m_k == N - 1);
            q.push_back(e);
            m_k++;
        end
        @(negedge clk);
    endtask

    task automatic run_tile(input logic [AW-1:0] base, input int gap_mode, input int data_mode,
                            input bit drop_en, input bit overrun);
        int            w0;
        int            g;
        int            t;
        logic [DW-1:0] d;
        @(negedge clk);
        enable = 1'b1;
        add_in = base;
        m_base = base;
        m_k    = 0;
        w0     = nwr;
        @(negedge clk);
        add_in = AW'($urandom);
        if (drop_en) enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            case (data_mode)
                0:       d = DW'(i + 1);
                1:       d = (i % 2 == 1) ? 8'h7F : 8'hF0;
                default: d = DW'($urandom);
            endcase
            send(d);
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 2));
            if (g > 0 && i < N - 1) begin
                in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
        end
        if (overrun) begin
            repeat (5) begin
                in_data = DW'($urandom);
                check("ready_after_last", 32'(in_ready), 32'd0);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        #1;
        t = 0;
        while (q.size() > 0 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain_pending", 32'(q.size()), 32'd0);
        check("write_count", 32'(nwr - w0), 32'(N));
        if (!drop_en) begin
            repeat (3) begin
                check("done_hold", 32'(done), 32'd1);
                check("ready_in_done", 32'(in_ready), 32'd0);
                @(negedge clk);
            end
            enable = 1'b0;
        end
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("ready_idle", 32'(in_ready), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_add_out", 32'(add_out), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;

        // in_valid while idle must be ignored
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        run_tile(14'h0100, 0, 0, 1'b0, 1'b0);   // basic tile
        run_tile(14'h0100, 1, 0, 1'b0, 1'b0);   // bursty 1-on/2-off
        run_tile(14'h0100, 0, 0, 1'b0, 1'b1);   // overrun guard

        // reset mid-tile after 7 transfers, with an 8th in flight
        @(negedge clk);
        enable = 1'b1;
        add_in = 14'h0180;
        m_base = 14'h0180;
        m_k    = 0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) send(DW'($urandom));
        in_data = 8'hA5;
        @(posedge clk);
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        q.delete();
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_add_out", 32'(add_out), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_tile(14'h0200, 0, 2, 1'b0, 1'b0);

        run_tile(14'h3FFE, 2, 2, 1'b0, 1'b0);   // address wrap
        run_tile(14'h0040, 0, 1, 1'b1, 1'b0);   // 0xF0/0x7F data, enable dropped in RUN

        for (int r = 0; r < 4; r++) begin
            run_tile(AW'($urandom), 2, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
